// File: rtl/mem_access_ctrl_pkg.sv
// Shared Y86 definitions for the memory-stage controller: icodes, status codes
// and the controller FSM encoding.
package mem_access_ctrl_pkg;

   localparam int DATA_WID = 64;
   localparam int ADDR_WID = 4;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_RRMOV = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] STAT_HLT = 4'h2;
   localparam logic [3:0] STAT_ADR = 4'h3;
   localparam logic [3:0] STAT_INS = 4'h4;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_REQ  = 2'd1,
      MS_DONE = 2'd2,
      MS_HALT = 2'd3
   } ms_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of a Y86 instruction into data-memory address, write
// data and access direction.
module mem_op_decode
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_WID,
   parameter int ICODE_W = ADDR_WID
) (
   input  logic [ICODE_W-1:0] icode,
   input  logic [DATA_W-1:0]  val_a,
   input  logic [DATA_W-1:0]  val_e,
   input  logic [DATA_W-1:0]  val_p,
   output logic [DATA_W-1:0]  addr,
   output logic [DATA_W-1:0]  wdata,
   output logic               rd,
   output logic               wr
);

   // Address/data/direction selection per icode.
   always_comb begin
      addr  = '0;
      wdata = '0;
      rd    = 1'b0;
      wr    = 1'b0;
      case (icode)
         I_RMMOV, I_PUSH: begin
            addr  = val_e;
            wdata = val_a;
            wr    = 1'b1;
         end
         I_CALL: begin
            addr  = val_e;
            wdata = val_p;
            wr    = 1'b1;
         end
         I_MRMOV: begin
            addr = val_e;
            rd   = 1'b1;
         end
         I_POP, I_RET: begin
            addr = val_a;
            rd   = 1'b1;
         end
         default: begin
            addr  = '0;
            wdata = '0;
            rd    = 1'b0;
            wr    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86 memory-stage controller: accepts decoded instructions, runs a req/ack
// data-memory access with timeout, and hands valM/status to write-back.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W   = DATA_WID,
   parameter int ICODE_W  = ADDR_WID,
   parameter int MEM_SIZE = 1024,
   parameter int TIMEOUT  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ICODE_W-1:0] in_icode,
   input  logic [ICODE_W-1:0] in_stat,
   input  logic [DATA_W-1:0]  in_valA,
   input  logic [DATA_W-1:0]  in_valE,
   input  logic [DATA_W-1:0]  in_valP,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ack,
   input  logic               dmem_err,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ICODE_W-1:0] out_icode,
   output logic [DATA_W-1:0]  out_valE,
   output logic [DATA_W-1:0]  out_valM,
   output logic [ICODE_W-1:0] out_stat,
   output logic               halted
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [DATA_W:0] BYTES_C = (DATA_W + 1)'(DATA_W / 8);
   localparam logic [DATA_W:0] LIMIT_C = (DATA_W + 1)'(MEM_SIZE);

   ms_state_e          state_r;
   logic [CNT_W-1:0]   wait_cnt_r;
   logic               rd_r;

   logic [DATA_W-1:0]  dec_addr_s;
   logic [DATA_W-1:0]  dec_wdata_s;
   logic               dec_rd_s;
   logic               dec_wr_s;
   logic [DATA_W:0]    end_addr_s;
   logic               oob_s;
   logic               accept_s;
   logic               launch_req_s;
   logic [ICODE_W-1:0] launch_stat_s;

   mem_op_decode #(
      .DATA_W  (DATA_W),
      .ICODE_W (ICODE_W)
   ) u_decode (
      .icode (in_icode),
      .val_a (in_valA),
      .val_e (in_valE),
      .val_p (in_valP),
      .addr  (dec_addr_s),
      .wdata (dec_wdata_s),
      .rd    (dec_rd_s),
      .wr    (dec_wr_s)
   );

   // One extra bit so an address near the top of the space cannot wrap past the check.
   assign end_addr_s = {1'b0, dec_addr_s} + BYTES_C;
   assign oob_s      = end_addr_s > LIMIT_C;

   assign in_ready = (state_r == MS_IDLE) ||
                     ((state_r == MS_DONE) && out_ready && (out_stat == STAT_AOK));
   assign accept_s = in_valid && in_ready;

   // Status priority for a newly accepted instruction and whether it needs the bus.
   always_comb begin
      launch_stat_s = STAT_AOK;
      launch_req_s  = 1'b0;
      if (in_stat != STAT_AOK) begin
         launch_stat_s = in_stat;
      end else if (in_icode == I_HALT) begin
         launch_stat_s = STAT_HLT;
      end else if ((dec_rd_s || dec_wr_s) && oob_s) begin
         launch_stat_s = STAT_ADR;
      end else if (dec_rd_s || dec_wr_s) begin
         launch_req_s = 1'b1;
      end else begin
         launch_stat_s = STAT_AOK;
      end
   end

   // Controller FSM with registered bus and write-back outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= MS_IDLE;
         wait_cnt_r <= '0;
         rd_r       <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         out_valid  <= 1'b0;
         out_icode  <= '0;
         out_valE   <= '0;
         out_valM   <= '0;
         out_stat   <= STAT_AOK;
         halted     <= 1'b0;
      end else begin
         case (state_r)
            MS_IDLE: begin
               out_valid <= 1'b0;
            end
            MS_REQ: begin
               if (dmem_ack && !dmem_err) begin
                  state_r   <= MS_DONE;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  out_valid <= 1'b1;
                  out_valM  <= rd_r ? dmem_rdata : '0;
                  out_stat  <= STAT_AOK;
               end else if (dmem_err || (wait_cnt_r == CNT_W'(TIMEOUT - 1))) begin
                  state_r   <= MS_DONE;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  out_valid <= 1'b1;
                  out_valM  <= '0;
                  out_stat  <= STAT_ADR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            MS_DONE: begin
               if (out_ready && (out_stat != STAT_AOK)) begin
                  state_r   <= MS_HALT;
                  out_valid <= 1'b0;
                  halted    <= 1'b1;
               end else if (out_ready) begin
                  state_r   <= MS_IDLE;
                  out_valid <= 1'b0;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            MS_HALT: begin
               halted    <= 1'b1;
               dmem_req  <= 1'b0;
               out_valid <= 1'b0;
            end
            default: begin
               state_r <= MS_IDLE;
            end
         endcase

         // Launch overrides the per-state defaults; only legal from IDLE or a clean DONE handshake.
         if (accept_s) begin
            state_r    <= launch_req_s ? MS_REQ : MS_DONE;
            wait_cnt_r <= '0;
            rd_r       <= dec_rd_s;
            dmem_req   <= launch_req_s;
            dmem_we    <= launch_req_s && dec_wr_s;
            dmem_addr  <= dec_addr_s;
            dmem_wdata <= dec_wdata_s;
            out_valid  <= !launch_req_s;
            out_icode  <= in_icode;
            out_valE   <= in_valE;
            out_valM   <= '0;
            out_stat   <= launch_stat_s;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with default parameters.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_icode;
   logic [3:0]  in_stat;
   logic [63:0] in_valA;
   logic [63:0] in_valE;
   logic [63:0] in_valP;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic        dmem_ack;
   logic        dmem_err;
   logic [63:0] dmem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_icode;
   logic [63:0] out_valE;
   logic [63:0] out_valM;
   logic [3:0]  out_stat;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt;

   mem_access_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_icode   (in_icode),
      .in_stat    (in_stat),
      .in_valA    (in_valA),
      .in_valE    (in_valE),
      .in_valP    (in_valP),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_err   (dmem_err),
      .dmem_rdata (dmem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_icode  (out_icode),
      .out_valE   (out_valE),
      .out_valM   (out_valM),
      .out_stat   (out_stat),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_icode   = 4'h1;
      in_stat    = 4'h1;
      in_valA    = 64'h0;
      in_valE    = 64'h0;
      in_valP    = 64'h0;
      dmem_ack   = 1'b0;
      dmem_err   = 1'b0;
      dmem_rdata = 64'h0;
      out_ready  = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                       input logic [63:0] vp, input logic [3:0] st);
      in_valid = 1'b1;
      in_icode = ic;
      in_valA  = va;
      in_valE  = ve;
      in_valP  = vp;
      in_stat  = st;
      chk("send_in_ready", {63'h0, in_ready}, 64'h1);
      tick();
      in_valid = 1'b0;
   endtask

   // Count req cycles; ack on req cycle ack_at (0 = never); garbage rdata otherwise.
   task automatic serve(input int ack_at, input logic [63:0] rd, output int n);
      n = 0;
      while (dmem_req && n < 40) begin
         n++;
         dmem_ack   = (n == ack_at);
         dmem_rdata = (n == ack_at) ? rd : 64'hBAD0_BAD0_BAD0_BAD0;
         tick();
      end
      dmem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      do_reset();
      chk("rst_req",      {63'h0, dmem_req},  64'h0);
      chk("rst_we",       {63'h0, dmem_we},   64'h0);
      chk("rst_out_valid",{63'h0, out_valid}, 64'h0);
      chk("rst_halted",   {63'h0, halted},    64'h0);
      chk("rst_stat",     {60'h0, out_stat},  64'h1);
      chk("rst_valM",     out_valM,           64'h0);
      chk("rst_in_ready", {63'h0, in_ready},  64'h1);

      // RMMOV with ack on third req cycle, write-back stalled one cycle
      out_ready = 1'b0;
      send(4'h4, 64'hDEAD, 64'h100, 64'h0, 4'h1);
      chk("rm_req",   {63'h0, dmem_req},  64'h1);
      chk("rm_we",    {63'h0, dmem_we},   64'h1);
      chk("rm_addr",  dmem_addr,          64'h100);
      chk("rm_wdata", dmem_wdata,         64'hDEAD);
      chk("rm_ov0",   {63'h0, out_valid}, 64'h0);
      serve(3, 64'h0, cnt);
      chk("rm_req_cycles", 64'(cnt),      64'd3);
      chk("rm_req_low",{63'h0, dmem_req}, 64'h0);
      chk("rm_ov",    {63'h0, out_valid}, 64'h1);
      chk("rm_stat",  {60'h0, out_stat},  64'h1);
      chk("rm_valM",  out_valM,           64'h0);
      chk("rm_icode", {60'h0, out_icode}, 64'h4);
      tick();
      chk("rm_hold_ov", {63'h0, out_valid}, 64'h1);
      chk("rm_hold_ir", {63'h0, in_ready},  64'h0);
      out_ready = 1'b1;
      tick();
      chk("rm_hs_ov", {63'h0, out_valid}, 64'h0);
      chk("rm_hs_ir", {63'h0, in_ready},  64'h1);

      // MRMOV with immediate ack: out_valid at k+2
      send(4'h5, 64'h0, 64'h20, 64'h0, 4'h1);
      chk("mr_ov_k1", {63'h0, out_valid}, 64'h0);
      chk("mr_we",    {63'h0, dmem_we},   64'h0);
      chk("mr_addr",  dmem_addr,          64'h20);
      serve(1, 64'h1234, cnt);
      chk("mr_req_cycles", 64'(cnt),      64'd1);
      chk("mr_ov",    {63'h0, out_valid}, 64'h1);
      chk("mr_valM",  out_valM,           64'h1234);
      chk("mr_stat",  {60'h0, out_stat},  64'h1);
      tick();

      // CALL acked on the 15th req cycle wins over timeout
      send(4'h8, 64'h0, 64'h200, 64'h40, 4'h1);
      chk("ca_addr",  dmem_addr,  64'h200);
      chk("ca_wdata", dmem_wdata, 64'h40);
      serve(15, 64'h0, cnt);
      chk("ca_ack15_cycles", 64'(cnt),    64'd15);
      chk("ca_ack15_stat", {60'h0, out_stat}, 64'h1);
      chk("ca_ack15_ov", {63'h0, out_valid}, 64'h1);
      tick();

      // Four back-to-back OPq, then HALT
      in_valid = 1'b1;
      in_icode = 4'h6;
      in_stat  = 4'h1;
      for (int i = 0; i < 4; i++) begin
         in_valE = 64'h1000 + 64'(i);
         tick();
         chk("op_ov",   {63'h0, out_valid}, 64'h1);
         chk("op_valE", out_valE,           64'h1000 + 64'(i));
         chk("op_stat", {60'h0, out_stat},  64'h1);
         chk("op_req",  {63'h0, dmem_req},  64'h0);
      end
      in_icode = 4'h0;
      in_valE  = 64'h0;
      tick();
      in_valid = 1'b0;
      chk("hlt_stat", {60'h0, out_stat},  64'h2);
      chk("hlt_ov",   {63'h0, out_valid}, 64'h1);
      chk("hlt_req",  {63'h0, dmem_req},  64'h0);
      chk("hlt_ir",   {63'h0, in_ready},  64'h0);
      tick();
      chk("hlt_halted", {63'h0, halted},  64'h1);
      chk("hlt_ir2",  {63'h0, in_ready},  64'h0);
      chk("hlt_ov2",  {63'h0, out_valid}, 64'h0);

      // CALL never acked: exactly 15 req cycles then ADR
      do_reset();
      chk("rst2_halted", {63'h0, halted}, 64'h0);
      send(4'h8, 64'h0, 64'h200, 64'h40, 4'h1);
      serve(0, 64'h0, cnt);
      chk("to_cycles", 64'(cnt),          64'd15);
      chk("to_stat",   {60'h0, out_stat}, 64'h3);
      chk("to_ov",     {63'h0, out_valid},64'h1);
      tick();
      chk("to_halted", {63'h0, halted},   64'h1);

      // POP just past the end of memory: ADR with no access, then permanent halt
      do_reset();
      send(4'hB, 64'h3FC, 64'h0, 64'h0, 4'h1);
      chk("pop_req",  {63'h0, dmem_req},  64'h0);
      chk("pop_ov",   {63'h0, out_valid}, 64'h1);
      chk("pop_stat", {60'h0, out_stat},  64'h3);
      chk("pop_valM", out_valM,           64'h0);
      tick();
      in_valid = 1'b1;
      in_icode = 4'h5;
      in_valE  = 64'h10;
      repeat (3) tick();
      chk("pop_halted", {63'h0, halted},  64'h1);
      chk("pop_ir",   {63'h0, in_ready},  64'h0);
      chk("pop_req2", {63'h0, dmem_req},  64'h0);
      chk("pop_ov2",  {63'h0, out_valid}, 64'h0);
      in_valid = 1'b0;

      // Non-OK fetch status passes through with no access
      do_reset();
      send(4'h4, 64'h1, 64'h100, 64'h0, 4'h4);
      chk("ins_req",  {63'h0, dmem_req}, 64'h0);
      chk("ins_stat", {60'h0, out_stat}, 64'h4);

      // Reset during REQ, then a normal MRMOV at the top word of memory
      do_reset();
      send(4'h5, 64'h0, 64'h30, 64'h0, 4'h1);
      tick();
      chk("mid_req", {63'h0, dmem_req}, 64'h1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_req", {63'h0, dmem_req},  64'h0);
      chk("mid_rst_ov",  {63'h0, out_valid}, 64'h0);
      rst_n = 1'b1;
      chk("mid_rst_ir",  {63'h0, in_ready},  64'h1);
      send(4'h5, 64'h0, 64'h3F8, 64'h0, 4'h1);
      chk("top_req", {63'h0, dmem_req}, 64'h1);
      serve(2, 64'h55AA, cnt);
      chk("top_cycles", 64'(cnt),          64'd2);
      chk("top_valM",   out_valM,          64'h55AA);
      chk("top_stat",   {60'h0, out_stat}, 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Parametrised, registered memory-stage controller for the Y86 pipeline. It takes one decoded instruction per handshake from the execute stage. It derives the data-memory address, write data and direction from `icode`, and drives a multi-cycle req/ack data-memory bus with a timeout. It then presents `valM` and the resolved status to write-back over a valid/ready handshake. It is sticky-halting: after any non-OK status is delivered, it refuses further instructions until reset.

## Interface

- Clock `clk`; reset `rst_n`, synchronous, active-low.

Parameters:
- `DATA_W`, default `` `DATA_WID ``: width of values and addresses.
- `ICODE_W`, default `` `ADDR_WID `` (4): width of icode and stat.
- `MEM_SIZE`, default 1024: data-memory size in bytes; valid accesses satisfy addr + DATA_W/8 ≤ MEM_SIZE.
- `TIMEOUT`, default 15: maximum cycles `dmem_req` waits for ack or error.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: controller can accept.
- `in_icode` in ICODE_W: instruction code.
- `in_stat` in ICODE_W: fetch status (`OK`/`INS`/`ADR`).
- `in_valA`, `in_valE`, `in_valP` in DATA_W: operand values.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out DATA_W: byte address.
- `dmem_wdata` out DATA_W: write data.
- `dmem_ack` in 1: access complete.
- `dmem_err` in 1: access faulted.
- `dmem_rdata` in DATA_W: read data, valid with ack.
- `out_valid` out 1: result valid.
- `out_ready` in 1: write-back accepts.
- `out_icode` out ICODE_W: registered icode.
- `out_valE` out DATA_W: registered valE.
- `out_valM` out DATA_W: read data, 0 for non-reads.
- `out_stat` out ICODE_W: resolved status.
- `halted` out 1: sticky halt flag.

## Operation

Decode:
- addr = valE for RMMOV/PUSH/CALL/MRMOV; addr = valA for POP/RET.
- wdata = valA for RMMOV/PUSH; wdata = valP for CALL.
- Read ops: MRMOV/RET/POP. Write ops: RMMOV/PUSH/CALL. All other icodes: no access, valM = 0.

Status priority, first match wins:
1. `in_stat` ≠ `OK` → pass through, no access.
2. icode = HALT → `HLT`.
3. Memory op with addr + DATA_W/8 > MEM_SIZE → `ADR`, no access.
4. `dmem_err`, or timeout → `ADR`.
5. Otherwise `OK`.

FSM states:
- IDLE:
  - Accept a no-access instruction → DONE.
  - Accept a memory op → REQ.
- REQ:
  - `dmem_req`=1; addr, we and wdata held stable.
  - Wait counter starts at 0 and increments each cycle without ack/err.
  - ack → DONE; valM captured when a read.
  - err, or counter = TIMEOUT−1 with no ack → DONE with `ADR`.
  - ack and err in the same cycle → `ADR`.
  - ack in the timeout cycle → ack wins, `OK`.
- DONE:
  - `out_valid`=1, outputs held until `out_ready`.
  - On handshake with `out_stat`=`OK`: accept a new instruction if `in_valid` (→ REQ or DONE), else → IDLE.
  - On handshake with `out_stat`≠`OK` → HALTED.
- HALTED: `halted`=1, `in_ready`=0, `dmem_req`=0; exited only by reset.

Handshake:
- `in_ready` = IDLE, or DONE && `out_ready` && `out_stat`=`OK`.
- A transfer occurs on the edge where valid && ready.

Reset:
- Reset low at any edge, including mid-REQ, → next cycle IDLE.
- Reset values: `dmem_req`=0, `dmem_we`=0, `out_valid`=0, `halted`=0; all data outputs 0; `out_stat`=`OK` (4'b0001).
- An outstanding memory access is abandoned; the memory model must tolerate a dropped req.

## Timing

- Instruction accepted at edge k.
- No-access instruction: `out_valid` from cycle k+1. Throughput is 1 per cycle with `out_ready` held high.
- Memory op: `dmem_req` from cycle k+1. Ack sampled at edge j → `dmem_req`=0 and `out_valid`=1 from cycle j+1. Minimum latency 2 cycles.
- Timeout: req asserted for exactly TIMEOUT cycles, then `out_valid` with `ADR` on the next cycle.
- `dmem_rdata` is sampled only on an ack edge.
- All outputs are registered; there is no combinational path from `dmem_*` to `out_*`.

## Structure

- `head.v` holds:
  - icode defines (`_RMMOV`, `_PUSH`, ...).
  - Status codes `OK`/`HLT`/`ADR`/`INS`.
  - New FSM encodings `MS_IDLE`, `MS_REQ`, `MS_DONE`, `MS_HALT`.
- One combinational sub-module, `mem_op_decode`: icode, valA/valE/valP → addr, wdata, rd, wr.
- The top level holds the FSM, timeout counter, bound check and output registers.

## Test plan

Defaults for all scenarios: DATA_W=64, MEM_SIZE=1024, TIMEOUT=15.

- RMMOV, valE=0x100, valA=0xDEAD; ack 3 cycles after req → req with we=1, addr 0x100, wdata 0xDEAD for 3 cycles; `out_valid` next cycle with `out_stat`=`OK`, valM=0.
- MRMOV, valE=0x20; immediate ack, rdata=0x1234 → valM=0x1234, `out_valid` at k+2.
- POP, valA=0x3FC → no req; `out_stat`=`ADR`; after handshake, `halted`=1 and `in_ready`=0 permanently.
- CALL, valP=0x40, never acked → req for exactly 15 cycles, then `ADR`. Rerun with ack on the 15th req cycle → `OK`.
- Back-to-back OPq ×4 with `out_ready`=1 → 4 results on 4 consecutive cycles. Then HALT → `HLT`, no req, `halted`=1.
- Reset low during REQ on cycle 2 → next cycle `dmem_req`=0, `out_valid`=0, `in_ready`=1 after release; a following MRMOV completes normally.
